pulse_timebase: RTL and testbench

Parametrised timebase for the pulse scheduler, the next generation of the free-running cycle counter. It adds a programmable prescaler, an optional wrap period, synchronous clear/load and a bank of one-shot compare channels, so the scheduler can fire pulses at exact timebase values. All outputs are registered.

---
 rtl/pulse_timebase.sv | 81 ++++++++
 tb/tb_pulse_timebase.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_timebase.sv
// Prescaled, optionally wrapping timebase counter with a bank of one-shot compare channels.
// Every output is registered and updates on the same edge as the advance it reports.
module pulse_timebase #(
  parameter int WIDTH      = 32,
  parameter int NUM_CMP    = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_value,
  input  logic [WIDTH-1:0]         period,
  input  logic [PRESCALE_W-1:0]    prescale,
  input  logic [NUM_CMP*WIDTH-1:0] cmp_value,
  input  logic [NUM_CMP-1:0]       cmp_arm,
  output logic [WIDTH-1:0]         count_out,
  output logic                     tick,
  output logic                     wrap,
  output logic [NUM_CMP-1:0]       cmp_hit,
  output logic [NUM_CMP-1:0]       cmp_armed
);

  logic [PRESCALE_W-1:0] pre_q;
  logic                  advance;
  logic [WIDTH-1:0]      count_next;
  logic                  wrap_next;
  logic [NUM_CMP-1:0]    hit_next;

  // clear and load both pre-empt an advance, so they suppress tick/wrap/hit too.
  always_comb begin
    advance   = en && !clear && !load_valid && (pre_q == prescale);
    hit_next  = '0;
    if ((period != '0) && (count_out >= period)) begin
      count_next = '0;
    end else begin
      count_next = count_out + 1'b1;
    end
    wrap_next = (count_next == '0);
    for (int i = 0; i < NUM_CMP; i++) begin
      hit_next[i] = advance && cmp_armed[i] &&
                    (count_next == cmp_value[i*WIDTH +: WIDTH]);
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
      pre_q     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      cmp_hit   <= '0;
      cmp_armed <= '0;
    end else begin
      tick      <= 1'b0;
      wrap      <= 1'b0;
      cmp_hit   <= hit_next;
      // A same-cycle arm wins over the disarm caused by a hit.
      cmp_armed <= (cmp_armed & ~hit_next) | cmp_arm;
      if (clear) begin
        count_out <= '0;
        pre_q     <= '0;
      end else if (load_valid) begin
        count_out <= load_value;
        pre_q     <= '0;
      end else if (en) begin
        if (pre_q == prescale) begin
          count_out <= count_next;
          pre_q     <= '0;
          tick      <= 1'b1;
          wrap      <= wrap_next;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_timebase.sv
// Scoreboard bench for pulse_timebase: stimulus pushes model predictions, a negedge monitor
// pops and compares them; directed scenarios are followed by a randomized run.
module tb_pulse_timebase;
  localparam int W  = 8;
  localparam int NC = 4;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en, clear, load_valid;
  logic [W-1:0]    load_value, period;
  logic [PW-1:0]   prescale;
  logic [NC*W-1:0] cmp_value;
  logic [NC-1:0]   cmp_arm;
  logic [W-1:0]    count_out;
  logic            tick, wrap;
  logic [NC-1:0]   cmp_hit, cmp_armed;

  pulse_timebase #(.WIDTH(W), .NUM_CMP(NC), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .load_valid(load_valid),
    .load_value(load_value), .period(period), .prescale(prescale),
    .cmp_value(cmp_value), .cmp_arm(cmp_arm), .count_out(count_out),
    .tick(tick), .wrap(wrap), .cmp_hit(cmp_hit), .cmp_armed(cmp_armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  count;
    logic          tick;
    logic          wrap;
    logic [NC-1:0] hit;
    logic [NC-1:0] armed;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  // Reference model state: plain integers rather than register images.
  int            m_cnt;
  int            m_pre;
  logic [NC-1:0] m_armed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_pre   = 0;
    m_armed = '0;
  endtask

  task automatic model_step(output exp_t e);
    int            nxt;
    logic [NC-1:0] armed_n;
    e.tick  = 1'b0;
    e.wrap  = 1'b0;
    e.hit   = '0;
    armed_n = m_armed;
    if (clear) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (load_valid) begin
      m_cnt = int'(load_value);
      m_pre = 0;
    end else if (en) begin
      if (m_pre == int'(prescale)) begin
        m_pre = 0;
        if (period != 0 && m_cnt >= int'(period)) nxt = 0;
        else nxt = (m_cnt + 1) % (1 << W);
        e.tick = 1'b1;
        e.wrap = (nxt == 0);
        for (int i = 0; i < NC; i++) begin
          if (m_armed[i] && nxt == int'(cmp_value[i*W +: W])) begin
            e.hit[i]   = 1'b1;
            armed_n[i] = 1'b0;
          end
        end
        m_cnt = nxt;
      end else begin
        m_pre = (m_pre + 1) % (1 << PW);
      end
    end
    m_armed = armed_n | cmp_arm;
    e.count = W'(m_cnt);
    e.armed = m_armed;
  endtask

  task automatic step();
    exp_t e;
    model_step(e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(phase, {count_out, tick, wrap, cmp_hit, cmp_armed},
            {mon_e.count, mon_e.tick, mon_e.wrap, mon_e.hit, mon_e.armed});
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; load_valid = 1'b0;
    load_value = '0; period = '0; prescale = '0; cmp_value = '0; cmp_arm = '0;
    model_reset();
    #1;
    check("reset_outputs", {count_out, tick, wrap, cmp_hit, cmp_armed}, 64'd0);
    #1 rst = 1'b0;

    phase = "free_run";
    en = 1'b1;
    repeat (5) step();
    check("free_run_count", count_out, 64'd5);
    check("free_run_tick", tick, 64'd1);

    phase = "prescale";
    clear = 1'b1; step(); clear = 1'b0;
    prescale = 8'd3;
    repeat (12) step();
    check("prescale_count", count_out, 64'd3);
    en = 1'b0;
    repeat (5) step();
    check("en_low_hold", count_out, 64'd3);
    en = 1'b1;
    repeat (4) step();
    check("prescale_resume", count_out, 64'd4);

    phase = "period";
    prescale = '0;
    clear = 1'b1; step(); clear = 1'b0;
    period = 8'd4;
    repeat (6) step();
    check("period_count", count_out, 64'd1);
    period = '0; load_value = 8'd9; load_valid = 1'b1; step(); load_valid = 1'b0;
    period = 8'd5;
    step();
    check("period_lowered", {count_out, wrap}, {8'd0, 1'b1});

    phase = "load_wrap";
    period = '0; load_value = 8'hFE; load_valid = 1'b1; step(); load_valid = 1'b0;
    check("load_no_tick", {count_out, tick}, {8'hFE, 1'b0});
    step();
    check("load_plus1", count_out, 64'hFF);
    step();
    check("full_wrap", {count_out, wrap}, {8'h00, 1'b1});

    phase = "compare";
    clear = 1'b1; step(); clear = 1'b0;
    period = 8'd9;
    cmp_value = {8'd0, 8'd0, 8'd100, 8'd7};
    cmp_arm = 4'b0011; step(); cmp_arm = '0;
    repeat (6) step();
    check("cmp0_hit", {count_out, cmp_hit[0], cmp_armed[0]}, {8'd7, 1'b1, 1'b0});
    repeat (12) step();
    check("cmp1_still_armed", cmp_armed[1], 64'd1);

    phase = "clear_load";
    period = '0; load_value = 8'd20; load_valid = 1'b1; step();
    clear = 1'b1; load_value = 8'd50; step();
    clear = 1'b0; load_valid = 1'b0;
    check("clear_over_load", count_out, 64'd0);
    cmp_value = {8'd0, 8'd1, 8'd100, 8'd7};
    en = 1'b0; cmp_arm = 4'b0100; step();
    en = 1'b1; step(); cmp_arm = '0;
    check("hit_and_rearm", {count_out, cmp_hit[2], cmp_armed[2]}, {8'd1, 1'b1, 1'b1});

    phase = "async_reset";
    repeat (3) step();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_reset", {count_out, tick, wrap, cmp_hit, cmp_armed}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("after_reset", {count_out, tick}, {8'd1, 1'b1});

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      en         = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 49) == 0);
      load_valid = ($urandom_range(0, 29) == 0);
      load_value = W'($urandom);
      if ($urandom_range(0, 59) == 0)
        period = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(1, 40));
      if ($urandom_range(0, 79) == 0) prescale = PW'($urandom_range(0, 3));
      for (int i = 0; i < NC; i++) begin
        cmp_arm[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 39) == 0) cmp_value[i*W +: W] = W'($urandom_range(0, 45));
      end
      step();
    end
    clear = 1'b0; load_valid = 1'b0; cmp_arm = '0;

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
